gpr_wr_arbiter: RTL
===================

Name: gpr_wr_arbiter

Overview:
Shares the single write port of the 32x32 general-purpose register file between two producers. The first is the in-order pipeline writeback ("p"). The second is the long-latency unit ("l"), which covers mult/div and multi-cycle loads. It holds a registered write stage that drives the file's write port, and it keeps a per-register pending mask of outstanding long-latency destinations that hazard logic consumes. A starvation guard bounds how long the long-latency unit can be held off by back-to-back pipeline writes.

Parameters:
STARVE_LIMIT, 4, consecutive p-over-l wins before l is forced to priority; legal range 1..15
CNT_W, 4, width of the starvation counter; must hold STARVE_LIMIT

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
p_valid  in  1  pipeline write request
p_ready  out  1  pipeline request granted this cycle (combinational)
p_addr  in  5  pipeline destination register
p_data  in  32  pipeline write data
p_pc8  in  32  PC+8 of the producing instruction, for trace
l_valid  in  1  long-latency write request
l_ready  out  1  long-latency request granted this cycle (combinational)
l_addr  in  5  long-latency destination register
l_data  in  32  long-latency write data
l_pc8  in  32  PC+8 of the producing instruction
l_issue  in  1  long-latency op issued; marks its destination pending
l_issue_addr  in  5  destination of the issued op
wrEnable  out  1  register-file write enable (registered)
wr  out  5  register-file write address (registered)
wrData  out  32  register-file write data (registered)
pc8  out  32  trace PC+8 forwarded with the write (registered)
pend  out  32  bit i set = register i awaits a long-latency write (registered)

Behaviour:
- Reset (while reset=1 at a clock edge):
  - wrEnable=0, wr=0, wrData=0, pc8=0, pend=0.
  - Counter=0, FSM=NORMAL.
  - p_ready=l_ready=0 while reset is high, regardless of valid.
- Handshake: a transfer occurs when valid&ready. At most one grant per cycle. ready never asserts without its valid. Requesters hold addr, data and pc8 stable until granted.
- Latency: grant in cycle N gives wrEnable=1 with the granted wr/wrData/pc8 in cycle N+1. With no grant in cycle N, wrEnable=0 in N+1 and wr/wrData/pc8 hold their previous values.
- Register 0: a grant with addr=0 completes the handshake, but wrEnable stays 0 the next cycle. wr/wrData/pc8 are not updated.
- FSM NORMAL:
  - Priority goes to p. p_ready=p_valid, and l_ready=l_valid&!p_valid.
  - Each cycle with p_valid&l_valid (p wins) increments the counter.
  - When the counter reaches STARVE_LIMIT on that increment, go to FAVOR_L.
  - Any l grant clears the counter. A cycle with !l_valid also clears the counter.
- FSM FAVOR_L:
  - Priority goes to l. l_ready=l_valid, and p_ready=p_valid&!l_valid.
  - On an l grant, or if l_valid=0, return to NORMAL with counter=0.
- Pending mask:
  - l_issue&(l_issue_addr!=0) sets pend[l_issue_addr] next cycle.
  - An l grant clears pend[l_addr] next cycle.
  - Set and clear of the same bit in the same cycle: set wins.
  - Set of a bit that is already set: it stays set.
  - A p grant never touches pend. A p write to a pending register is legal.
  - pend[0] is always 0.
- No internal buffering beyond the single output register. Back-pressure is purely through ready.
- Reset asserted mid-stream: the in-flight write in the output register is dropped (wrEnable=0 next cycle), and pending bits are lost.

Test Plan:
- Reset 3 cycles with p_valid=l_valid=1 -> p_ready=l_ready=0. After reset: wrEnable=0, pend=0.
- Single p write, addr=5, data=0xDEADBEEF, pc8=0x00400008 -> p_ready=1 in cycle N. Cycle N+1: wrEnable=1, wr=5, wrData=0xDEADBEEF, pc8=0x00400008. Cycle N+2: wrEnable=0.
- STARVE_LIMIT=4, p_valid and l_valid held high, l_addr=9 -> p granted cycles 0-3, l granted cycle 4, p granted cycles 5-8, l granted cycle 9. The counter pattern repeats.
- l_issue addr=12 at cycle 0 -> pend=0x00001000 from cycle 1. l grant addr=12 at cycle 5 -> pend=0 from cycle 6. l_issue and l grant on addr 12 in the same cycle -> bit stays 1.
- p grant addr=0, data=0x1234 -> handshake completes, wrEnable=0 the next cycle, wr/wrData unchanged. l_issue addr=0 -> pend stays 0.
- Reset asserted in the same cycle as an l grant to addr 7 with pend[7]=1 -> next cycle: wrEnable=0, pend=0, FSM=NORMAL, counter=0.

Source files
------------

// File: rtl/gpr_wr_arbiter.sv
// Write-port arbiter for the 32x32 GPR file: pipeline writeback vs long-latency unit,
// with a registered write stage, a starvation guard and a pending-destination mask.
module gpr_wr_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        p_valid,
    output logic        p_ready,
    input  logic [4:0]  p_addr,
    input  logic [31:0] p_data,
    input  logic [31:0] p_pc8,

    input  logic        l_valid,
    output logic        l_ready,
    input  logic [4:0]  l_addr,
    input  logic [31:0] l_data,
    input  logic [31:0] l_pc8,

    input  logic        l_issue,
    input  logic [4:0]  l_issue_addr,

    output logic        wrEnable,
    output logic [4:0]  wr,
    output logic [31:0] wrData,
    output logic [31:0] pc8,
    output logic [31:0] pend
);

    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_FAVOR_L = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_q, wr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] pc8_q, pc8_d;
    logic [31:0] pend_q, pend_d;

    logic        p_grant;
    logic        l_grant;
    logic [31:0] pend_set;
    logic [31:0] pend_clr;

    // Readies are forced low during reset so nothing handshakes into a flop being cleared.
    always_comb begin
        p_ready = 1'b0;
        l_ready = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_NORMAL: begin
                    p_ready = p_valid;
                    l_ready = l_valid & ~p_valid;
                end
                ST_FAVOR_L: begin
                    l_ready = l_valid;
                    p_ready = p_valid & ~l_valid;
                end
                default: begin
                    p_ready = 1'b0;
                    l_ready = 1'b0;
                end
            endcase
        end
    end

    assign p_grant = p_valid & p_ready;
    assign l_grant = l_valid & l_ready;

    // Starvation guard: count consecutive cycles where l was held off by p.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_NORMAL: begin
                if (p_valid && l_valid) begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_d == LIMIT) begin
                        state_d = ST_FAVOR_L;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_FAVOR_L: begin
                if (l_grant || !l_valid) begin
                    state_d = ST_NORMAL;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_NORMAL;
                cnt_d   = '0;
            end
        endcase
    end

    // Writes to r0 are accepted but never reach the file; the stage keeps its old contents.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_d      = wr_q;
        wr_data_d = wr_data_q;
        pc8_d     = pc8_q;
        if (p_grant && (p_addr != 5'd0)) begin
            wr_en_d   = 1'b1;
            wr_d      = p_addr;
            wr_data_d = p_data;
            pc8_d     = p_pc8;
        end else if (l_grant && (l_addr != 5'd0)) begin
            wr_en_d   = 1'b1;
            wr_d      = l_addr;
            wr_data_d = l_data;
            pc8_d     = l_pc8;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi = gi + 1) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pend_set[gi] = 1'b0;
                assign pend_clr[gi] = 1'b0;
                assign pend_d[gi]   = 1'b0;
            end else begin : g_bit
                assign pend_set[gi] = l_issue & (l_issue_addr == 5'(gi));
                assign pend_clr[gi] = l_grant & (l_addr == 5'(gi));
                // A new issue to the same register outranks the retiring write.
                assign pend_d[gi]   = pend_set[gi] | (pend_q[gi] & ~pend_clr[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_NORMAL;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_q      <= 5'd0;
            wr_data_q <= 32'd0;
            pc8_q     <= 32'd0;
            pend_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_q      <= wr_d;
            wr_data_q <= wr_data_d;
            pc8_q     <= pc8_d;
            pend_q    <= pend_d;
        end
    end

    assign wrEnable = wr_en_q;
    assign wr       = wr_q;
    assign wrData   = wr_data_q;
    assign pc8      = pc8_q;
    assign pend     = pend_q;

endmodule
